sender_carrier_nco: RTL and testbench
=====================================

// Module: sender_carrier_nco
// PURPOSE
//  Numerically controlled oscillator generating the 16-bit signed cosine carrier that the sender
//  modulator multiplies with baseband x_in. Sits directly upstream of the modulator multiplier,
//  in the same 30.72 MHz domain.
//  32-bit phase accumulator, programmable frequency word and phase offset, quarter-wave cosine
//  table, 3-stage output pipeline with a valid strobe.
// PARAMETERS
//  PHASE_W   32           accumulator / frequency word / phase offset width
//  FREQ_RST  32'h0000_0000 frequency register value after reset
// PORTS
//  clk_30p72MHz  in   1   system clock, all logic on rising edge
//  reset         in   1   synchronous, active-high reset
//  freq_in       in   32  frequency word (phase increment per sample)
//  freq_load     in   1   1-cycle strobe: capture freq_in into freq_reg
//  phase_off     in   32  static phase offset added before table lookup
//  sync_clr      in   1   restart phase: sample taken at phase 0
//  ce            in   1   sample enable: take one sample, advance accumulator
//  cos_out       out  16  signed carrier sample to modulator (cosine port)
//  cos_valid     out  1   cos_out holds a new sample this cycle
// BEHAVIOUR
//  - Reset: acc=0, freq_reg=FREQ_RST, all pipeline regs 0, cos_out=0, cos_valid=0.
//    Reset mid-operation discards samples in flight; no valid pulse for them.
//  - freq_load=1: freq_reg<=freq_in on that edge.
//    If ce is also 1 on that edge, the increment applied on that edge is the OLD freq_reg.
//  - ce=1, sync_clr=0: sample phase P=acc; acc<=acc+freq_reg (mod 2^32).
//  - ce=1, sync_clr=1: sample phase P=0; acc<=freq_reg.
//  - ce=0, sync_clr=1: acc<=0, no sample taken.
//  - ce=0, sync_clr=0: acc holds.
//  - Pipeline: S1 a<=(P+phase_off)[31:24]; S2 table read plus quadrant flags; S3 sign/negate into cos_out.
//    Result: cos_out and cos_valid are updated 3 edges after the ce edge.
//    cos_valid is the ce pipeline (1,1,1 tap delay).
//    cos_out holds its last value when cos_valid=0.
//  - Table: T[k]=round(32767*cos(2*pi*k/256)), k=0..64 (65 entries, ROM/case).
//    T[0]=32767, T[1]=32757, T[32]=23170, T[64]=0.
//  - Address split: q=a[7:6], i=a[5:0]:
//    q0: +T[i]   q1: -T[64-i]   q2: -T[i]   q3: +T[64-i]
//  - Range: output never exceeds +/-32767; -32768 is never produced (negation cannot overflow).
//  - Continuous ce=1 with freq F: output period = 2^32/F samples. Accumulator wrap is silent and phase-continuous.
// TESTING
//  1 Reset, ce=0 -> cos_out=0, cos_valid=0 for 10 cycles.
//    Assert reset mid-stream -> cos_valid=0 on the next edge and stays 0 for 3 cycles after release with ce=1.
//  2 freq_load 0x0100_0000, then ce=1 continuously -> 256-sample period.
//    Samples n=0,1,32,64,128,192 = 32767, 32757, 23170, 0, -32767, 0.
//    First cos_valid 3 edges after the first ce edge.
//  3 freq 0x4000_0000 -> repeating sequence 32767, 0, -32767, 0.
//    Same freq with phase_off=0x4000_0000 -> 0, -32767, 0, 32767.
//  4 ce toggling 1,0,1,0 with freq 0x0100_0000 -> valid on alternate cycles.
//    Valid samples are consecutive table points: 32767, 32757, ... with no skipped phase.
//  5 freq_load with ce=1 on the same edge (old 0x0100_0000, new 0x0200_0000):
//    sample phases 0, 0x01.., 0x03.., 0x05.. (top byte 0, 1, 3, 5).
//  6 sync_clr with ce=1 after 10 samples -> that sample equals 32767.
//    Next sample equals T[1]=32757 at freq 0x0100_0000.
//    freq 0xFFFF_FFFF runs 2^32 wrap without glitch (check accumulator model).

Source files
------------

// File: rtl/sender_carrier_nco_if.sv
// Control and sample bus between the carrier NCO and its user (modulator side).
// Slave modport is the NCO; master modport drives frequency/phase/enable and receives samples.
interface sender_carrier_nco_if #(
    parameter int unsigned PHASE_W = 32
);
    logic [PHASE_W-1:0] freq_in;
    logic               freq_load;
    logic [PHASE_W-1:0] phase_off;
    logic               sync_clr;
    logic               ce;
    logic signed [15:0] cos_out;
    logic               cos_valid;

    modport master (
        output freq_in, freq_load, phase_off, sync_clr, ce,
        input  cos_out, cos_valid
    );

    modport slave (
        input  freq_in, freq_load, phase_off, sync_clr, ce,
        output cos_out, cos_valid
    );
endinterface

// File: rtl/sender_carrier_nco.sv
// Carrier NCO: 32-bit phase accumulator, quarter-wave cosine ROM, 3-stage output pipeline.
// Produces the signed 16-bit cosine carrier for the sender modulator multiplier.
module sender_carrier_nco #(
    parameter int unsigned        PHASE_W  = 32,
    parameter logic [PHASE_W-1:0] FREQ_RST = '0
) (
    input  logic                 clk_30p72MHz,
    input  logic                 reset,
    sender_carrier_nco_if.slave  nco
);
    logic [PHASE_W-1:0] acc_q, acc_d;
    logic [PHASE_W-1:0] freq_q, freq_d;
    logic [PHASE_W-1:0] phase_p;
    logic [7:0]         addr_q, addr_d;
    logic               v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    logic               neg_q, neg_d;
    logic [14:0]        mag_q, mag_d;
    logic signed [15:0] cos_q, cos_d;
    logic [6:0]         rom_idx;

    // First quadrant of round(32767*cos(2*pi*k/256)), k = 0..64.
    function automatic logic [14:0] cos_rom(input logic [6:0] k);
        case (k)
            7'd0:  cos_rom = 15'd32767; 7'd1:  cos_rom = 15'd32757; 7'd2:  cos_rom = 15'd32728; 7'd3:  cos_rom = 15'd32678;
            7'd4:  cos_rom = 15'd32609; 7'd5:  cos_rom = 15'd32521; 7'd6:  cos_rom = 15'd32412; 7'd7:  cos_rom = 15'd32285;
            7'd8:  cos_rom = 15'd32137; 7'd9:  cos_rom = 15'd31971; 7'd10: cos_rom = 15'd31785; 7'd11: cos_rom = 15'd31580;
            7'd12: cos_rom = 15'd31356; 7'd13: cos_rom = 15'd31113; 7'd14: cos_rom = 15'd30852; 7'd15: cos_rom = 15'd30571;
            7'd16: cos_rom = 15'd30273; 7'd17: cos_rom = 15'd29956; 7'd18: cos_rom = 15'd29621; 7'd19: cos_rom = 15'd29268;
            7'd20: cos_rom = 15'd28898; 7'd21: cos_rom = 15'd28510; 7'd22: cos_rom = 15'd28105; 7'd23: cos_rom = 15'd27683;
            7'd24: cos_rom = 15'd27245; 7'd25: cos_rom = 15'd26790; 7'd26: cos_rom = 15'd26319; 7'd27: cos_rom = 15'd25832;
            7'd28: cos_rom = 15'd25329; 7'd29: cos_rom = 15'd24811; 7'd30: cos_rom = 15'd24279; 7'd31: cos_rom = 15'd23731;
            7'd32: cos_rom = 15'd23170; 7'd33: cos_rom = 15'd22594; 7'd34: cos_rom = 15'd22005; 7'd35: cos_rom = 15'd21403;
            7'd36: cos_rom = 15'd20787; 7'd37: cos_rom = 15'd20159; 7'd38: cos_rom = 15'd19519; 7'd39: cos_rom = 15'd18868;
            7'd40: cos_rom = 15'd18204; 7'd41: cos_rom = 15'd17530; 7'd42: cos_rom = 15'd16846; 7'd43: cos_rom = 15'd16151;
            7'd44: cos_rom = 15'd15446; 7'd45: cos_rom = 15'd14732; 7'd46: cos_rom = 15'd14010; 7'd47: cos_rom = 15'd13279;
            7'd48: cos_rom = 15'd12539; 7'd49: cos_rom = 15'd11793; 7'd50: cos_rom = 15'd11039; 7'd51: cos_rom = 15'd10278;
            7'd52: cos_rom = 15'd9512;  7'd53: cos_rom = 15'd8739;  7'd54: cos_rom = 15'd7962;  7'd55: cos_rom = 15'd7179;
            7'd56: cos_rom = 15'd6393;  7'd57: cos_rom = 15'd5602;  7'd58: cos_rom = 15'd4808;  7'd59: cos_rom = 15'd4011;
            7'd60: cos_rom = 15'd3212;  7'd61: cos_rom = 15'd2410;  7'd62: cos_rom = 15'd1608;  7'd63: cos_rom = 15'd804;
            default: cos_rom = '0;
        endcase
    endfunction

    always_comb begin
        // Increment uses the frequency register as it stood before any same-edge load.
        freq_d  = nco.freq_load ? nco.freq_in : freq_q;
        phase_p = nco.sync_clr ? '0 : acc_q;
        acc_d   = acc_q;
        if (nco.ce) begin
            acc_d = phase_p + freq_q;
        end else if (nco.sync_clr) begin
            acc_d = '0;
        end

        addr_d  = 8'((phase_p + nco.phase_off) >> (PHASE_W - 8));
        v1_d    = nco.ce;

        // Quadrants 1 and 3 read the table mirrored; quadrants 1 and 2 are negated.
        rom_idx = addr_q[6] ? (7'd64 - {1'b0, addr_q[5:0]}) : {1'b0, addr_q[5:0]};
        mag_d   = cos_rom(rom_idx);
        neg_d   = addr_q[7] ^ addr_q[6];
        v2_d    = v1_q;

        cos_d   = cos_q;
        if (v2_q) begin
            cos_d = neg_q ? -signed'({1'b0, mag_q}) : signed'({1'b0, mag_q});
        end
        v3_d    = v2_q;
    end

    always_ff @(posedge clk_30p72MHz) begin
        if (reset) begin
            acc_q  <= '0;
            freq_q <= FREQ_RST;
            addr_q <= '0;
            v1_q   <= 1'b0;
            mag_q  <= '0;
            neg_q  <= 1'b0;
            v2_q   <= 1'b0;
            cos_q  <= '0;
            v3_q   <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            freq_q <= freq_d;
            addr_q <= addr_d;
            v1_q   <= v1_d;
            mag_q  <= mag_d;
            neg_q  <= neg_d;
            v2_q   <= v2_d;
            cos_q  <= cos_d;
            v3_q   <= v3_d;
        end
    end

    assign nco.cos_out   = cos_q;
    assign nco.cos_valid = v3_q;
endmodule

// File: tb/tb_sender_carrier_nco.sv
// Self-checking bench for sender_carrier_nco: directed spec scenarios plus randomized traffic,
// compared against a real-arithmetic cosine model with a per-edge sample delay queue.
module tb_sender_carrier_nco;
    localparam real PI = 3.14159265358979323846;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sender_carrier_nco_if #(.PHASE_W(32)) nco_if();

    sender_carrier_nco #(.PHASE_W(32), .FREQ_RST(32'h0000_0000)) dut (
        .clk_30p72MHz (clk),
        .reset        (rst),
        .nco          (nco_if)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Reference model state
    logic [31:0] m_acc, m_freq;
    int          m_out;
    bit          m_valid;
    bit          q_v[$];
    int          q_val[$];

    // Observation log for directed checks
    int          got[$];
    int          edge_cnt;
    int          first_valid_edge;
    int          valid_cnt;
    logic [31:0] cur_off;

    function automatic int ref_cos(input logic [7:0] a);
        real r;
        r = 32767.0 * $cos(2.0 * PI * real'(a) / 256.0);
        return $rtoi($floor(r + 0.5));
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic check_got(input string tag, input int idx, input int exp);
        int obs;
        obs = (idx < got.size()) ? got[idx] : 32'h7FFF_FFFF;
        check(tag, obs, exp);
    endtask

    task automatic model_reset();
        m_acc   = '0;
        m_freq  = 32'h0000_0000;
        m_out   = 0;
        m_valid = 1'b0;
        q_v.delete();
        q_val.delete();
        repeat (2) begin
            q_v.push_back(1'b0);
            q_val.push_back(0);
        end
    endtask

    // One clock: drive at negedge, model the edge, check #1 after the edge.
    task automatic step(input bit r, input bit c, input bit s, input bit l, input logic [31:0] f);
        logic [31:0] p, ph;
        int          v;
        @(negedge clk);
        rst              = r;
        nco_if.ce        = c;
        nco_if.sync_clr  = s;
        nco_if.freq_load = l;
        nco_if.freq_in   = f;
        nco_if.phase_off = cur_off;
        @(posedge clk);
        if (r) begin
            model_reset();
        end else begin
            if (c) begin
                p  = s ? 32'h0 : m_acc;
                ph = p + cur_off;
                q_v.push_back(1'b1);
                q_val.push_back(ref_cos(ph[31:24]));
                m_acc = s ? m_freq : m_acc + m_freq;
            end else begin
                q_v.push_back(1'b0);
                q_val.push_back(0);
                if (s) m_acc = '0;
            end
            if (l) m_freq = f;
            m_valid = q_v.pop_front();
            v       = q_val.pop_front();
            if (m_valid) m_out = v;
        end
        #1;
        check("cos_valid", {31'd0, nco_if.cos_valid}, {31'd0, m_valid});
        check("cos_out", nco_if.cos_out, m_out);
        if (nco_if.cos_valid === 1'b1) begin
            got.push_back(int'(nco_if.cos_out));
            valid_cnt++;
            if (first_valid_edge < 0) first_valid_edge = edge_cnt;
        end
        edge_cnt++;
    endtask

    task automatic start_log();
        got.delete();
        edge_cnt         = 0;
        first_valid_edge = -1;
        valid_cnt        = 0;
    endtask

    task automatic flush();
        repeat (3) step(0, 0, 0, 0, 32'h0);
    endtask

    initial begin
        rst              = 1'b1;
        nco_if.ce        = 1'b0;
        nco_if.sync_clr  = 1'b0;
        nco_if.freq_load = 1'b0;
        nco_if.freq_in   = '0;
        nco_if.phase_off = '0;
        cur_off          = '0;
        model_reset();
        start_log();

        // Reset and idle
        repeat (2) step(1, 0, 0, 0, 32'h0);
        repeat (10) step(0, 0, 0, 0, 32'h0);
        check("idle_no_valid", valid_cnt, 0);

        // 256-sample period at F = 2^24
        step(0, 0, 1, 1, 32'h0100_0000);
        start_log();
        repeat (259) step(0, 1, 0, 0, 32'h0);
        check("first_valid_latency", first_valid_edge, 2);
        check_got("p256_n0", 0, 32767);
        check_got("p256_n1", 1, 32757);
        check_got("p256_n32", 32, 23170);
        check_got("p256_n64", 64, 0);
        check_got("p256_n128", 128, -32767);
        check_got("p256_n192", 192, 0);
        check_got("p256_period", 256, 32767);

        // Mid-stream reset: no valid for samples in flight, 3-edge restart
        step(1, 1, 0, 0, 32'h0);
        check("reset_kills_valid", {31'd0, nco_if.cos_valid}, 32'd0);
        start_log();
        repeat (4) step(0, 1, 0, 0, 32'h0);
        check("post_reset_latency", first_valid_edge, 2);
        flush();

        // Quarter-rate carrier, then with 90 degree offset
        step(0, 0, 1, 1, 32'h4000_0000);
        start_log();
        repeat (8) step(0, 1, 0, 0, 32'h0);
        flush();
        check_got("qr_0", 0, 32767);
        check_got("qr_1", 1, 0);
        check_got("qr_2", 2, -32767);
        check_got("qr_3", 3, 0);
        check_got("qr_4", 4, 32767);
        cur_off = 32'h4000_0000;
        step(0, 0, 1, 0, 32'h0);
        start_log();
        repeat (4) step(0, 1, 0, 0, 32'h0);
        flush();
        check_got("qr_off_0", 0, 0);
        check_got("qr_off_1", 1, -32767);
        check_got("qr_off_2", 2, 0);
        check_got("qr_off_3", 3, 32767);
        cur_off = 32'h0;

        // ce toggling: alternate valids, no skipped phase
        step(0, 0, 1, 1, 32'h0100_0000);
        start_log();
        for (int i = 0; i < 16; i++) step(0, (i % 2) == 0, 0, 0, 32'h0);
        flush();
        check("toggle_valid_count", valid_cnt, 8);
        check_got("toggle_0", 0, 32767);
        check_got("toggle_1", 1, 32757);
        check_got("toggle_2", 2, 32728);
        check_got("toggle_3", 3, 32678);

        // freq_load with ce on the same edge: old increment applies first
        step(0, 0, 1, 1, 32'h0100_0000);
        start_log();
        step(0, 1, 0, 1, 32'h0200_0000);
        repeat (3) step(0, 1, 0, 0, 32'h0);
        flush();
        check_got("load_ce_0", 0, 32767);
        check_got("load_ce_1", 1, 32757);
        check_got("load_ce_2", 2, 32678);
        check_got("load_ce_3", 3, 32521);

        // sync_clr with ce after 10 samples
        step(0, 0, 1, 1, 32'h0100_0000);
        start_log();
        repeat (10) step(0, 1, 0, 0, 32'h0);
        step(0, 1, 1, 0, 32'h0);
        step(0, 1, 0, 0, 32'h0);
        flush();
        check_got("sync_sample", 10, 32767);
        check_got("sync_next", 11, 32757);

        // Maximal increment: accumulator wraps every sample
        step(0, 0, 1, 1, 32'hFFFF_FFFF);
        start_log();
        repeat (300) step(0, 1, 0, 0, 32'h0);
        flush();
        check_got("wrap_0", 0, 32767);
        check_got("wrap_1", 1, 32757);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 31) == 0) cur_off = $urandom;
            step($urandom_range(0, 63) == 0,
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 15) == 0,
                 $urandom_range(0, 11) == 0,
                 $urandom);
        end
        flush();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
